// File: rtl/ysyx_210238_wb_sched_pkg.sv
// Shared constants for the write-back scheduler.
// Holds the data and address widths, the register count, the write-back source
// encoding used by the arbiter, and a popcount helper for the scoreboard.
package ysyx_210238_wb_sched_pkg;

  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;

  // Write-back source index.
  // This is also the bit position of that source in the arbiter's req/gnt vectors.
  localparam logic SRC_EXU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  function automatic logic [5:0] popcnt(input logic [NREG-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/ysyx_210238_wb_rr_arb2.sv
// 2-way round-robin arbiter for the register-file write port.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : request vector, indexed by SRC_EXU / SRC_LSU
//   gnt[1:0] : one-hot grant, combinational from req and the pointer
// The pointer remembers the last granted source. It moves only on a grant.
// Reset leaves the pointer at "LSU last", so EXU wins the first conflict.
module ysyx_210238_wb_rr_arb2
  import ysyx_210238_wb_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last == SRC_LSU) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         last <= SRC_LSU;
    else if (|gnt)   last <= gnt[SRC_LSU];
  end

endmodule

// File: rtl/ysyx_210238_wb_sched.sv
// Write-back scheduler and busy scoreboard for the 32x64 integer register file.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   i_iss_*             : issue-side view of the instruction being issued (rd, rs1, rs2)
//   o_iss_stall         : RAW/WAW hazard; issue must not proceed this cycle
//   i_exu_*, o_exu_ready: EXU write-back valid/ready request
//   i_lsu_*, o_lsu_ready: LSU write-back valid/ready request
//   o_rf_*              : registered register-file write port (1-cycle latency)
//   o_busy, o_pend_cnt  : scoreboard vector and its population count
module ysyx_210238_wb_sched
  import ysyx_210238_wb_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_iss_valid,
  input  logic            i_iss_rd_wen,
  input  logic [AW-1:0]   i_iss_rd_addr,
  input  logic            i_iss_rs1_cen,
  input  logic [AW-1:0]   i_iss_rs1_addr,
  input  logic            i_iss_rs2_cen,
  input  logic [AW-1:0]   i_iss_rs2_addr,
  output logic            o_iss_stall,
  input  logic            i_exu_valid,
  input  logic [AW-1:0]   i_exu_addr,
  input  logic [XLEN-1:0] i_exu_wdata,
  output logic            o_exu_ready,
  input  logic            i_lsu_valid,
  input  logic [AW-1:0]   i_lsu_addr,
  input  logic [XLEN-1:0] i_lsu_wdata,
  output logic            o_lsu_ready,
  output logic            o_rf_wen,
  output logic [AW-1:0]   o_rf_addr,
  output logic [XLEN-1:0] o_rf_wdata,
  output logic [NREG-1:0] o_busy,
  output logic [5:0]      o_pend_cnt
);

  logic [1:0]      gnt;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_wdata;
  logic            rs1_haz, rs2_haz, waw_haz;
  logic            iss_set;
  logic [NREG-1:0] busy_nxt;

  ysyx_210238_wb_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({i_lsu_valid, i_exu_valid}),
    .gnt (gnt)
  );

  assign o_exu_ready = gnt[SRC_EXU];
  assign o_lsu_ready = gnt[SRC_LSU];
  assign sel_addr    = gnt[SRC_LSU] ? i_lsu_addr  : i_exu_addr;
  assign sel_wdata   = gnt[SRC_LSU] ? i_lsu_wdata : i_exu_wdata;

  // A register being written this cycle is not a hazard.
  // The register file forwards the write data to readers in the same cycle.
  // busy[0] is never set, so x0 never produces a hazard.
  assign rs1_haz = i_iss_rs1_cen & o_busy[i_iss_rs1_addr]
                 & ~(o_rf_wen & (o_rf_addr == i_iss_rs1_addr));
  assign rs2_haz = i_iss_rs2_cen & o_busy[i_iss_rs2_addr]
                 & ~(o_rf_wen & (o_rf_addr == i_iss_rs2_addr));
  assign waw_haz = i_iss_rd_wen  & o_busy[i_iss_rd_addr]
                 & ~(o_rf_wen & (o_rf_addr == i_iss_rd_addr));

  assign o_iss_stall = rst | (i_iss_valid & (rs1_haz | rs2_haz | waw_haz));

  assign iss_set = i_iss_valid & ~o_iss_stall & i_iss_rd_wen & (i_iss_rd_addr != '0);

  // Clear first, then set: when the same register is cleared and set in one
  // cycle, the set wins.
  always_comb begin
    busy_nxt = o_busy;
    if (o_rf_wen) busy_nxt[o_rf_addr] = 1'b0;
    if (iss_set)  busy_nxt[i_iss_rd_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_busy     <= '0;
      o_pend_cnt <= '0;
      o_rf_wen   <= 1'b0;
      o_rf_addr  <= '0;
      o_rf_wdata <= '0;
    end else begin
      o_busy     <= busy_nxt;
      o_pend_cnt <= popcnt(busy_nxt);
      // A write-back to x0 is accepted, but it does not raise the write enable.
      o_rf_wen   <= (|gnt) & (sel_addr != '0);
      if (|gnt) begin
        o_rf_addr  <= sel_addr;
        o_rf_wdata <= sel_wdata;
      end
    end
  end

endmodule

// File: doc/ysyx_210238_wb_sched.md
Name: ysyx_210238_wb_sched

Overview:
Write-back scheduler and scoreboard for the 32x64 integer register file.
- Two write-back sources share the single register-file write port: EXU results and LSU load data. The block arbitrates between them round-robin and drives the write port from a registered stage.
- It tracks pending destination registers in a busy scoreboard, and stalls issue on RAW and WAW hazards.
- It sits between decode/issue, EXU/LSU write-back, and the register file.

Parameters:
XLEN, 64, data width of write-back and register-file write data
AW, 5, register address width
NREG, 32, number of architectural registers (2**AW)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
i_iss_valid  input  1  decoder presents an instruction for issue
i_iss_rd_wen  input  1  instruction writes rd
i_iss_rd_addr  input  AW  destination register
i_iss_rs1_cen  input  1  rs1 is read
i_iss_rs1_addr  input  AW  source register 1
i_iss_rs2_cen  input  1  rs2 is read
i_iss_rs2_addr  input  AW  source register 2
o_iss_stall  output  1  hazard; issue must not proceed this cycle
i_exu_valid  input  1  EXU write-back request
i_exu_addr  input  AW  EXU destination
i_exu_wdata  input  XLEN  EXU result
o_exu_ready  output  1  EXU request accepted this cycle
i_lsu_valid  input  1  LSU write-back request
i_lsu_addr  input  AW  LSU destination
i_lsu_wdata  input  XLEN  LSU load data
o_lsu_ready  output  1  LSU request accepted this cycle
o_rf_wen  output  1  register-file write enable
o_rf_addr  output  AW  register-file write address
o_rf_wdata  output  XLEN  register-file write data
o_busy  output  NREG  scoreboard vector; bit 0 is always 0
o_pend_cnt  output  6  number of set busy bits

Behaviour:
Reset and clock:
- One clock domain (clk); reset is synchronous and active-high (rst).
- While rst=1: o_rf_wen=0, o_rf_addr=0, o_rf_wdata=0, o_busy=0, o_pend_cnt=0, o_exu_ready=0, o_lsu_ready=0, o_iss_stall=1.
- Reset mid-operation discards all pending state: busy bits and the output stage. The round-robin pointer resets to "LSU last", so EXU wins the first conflict.

Handshake:
- A request is accepted when valid and ready are both 1 in the same cycle.
- Sources hold valid, addr and wdata stable until accepted.
- o_*_ready is combinational from the grant and does not depend on ready of the other source.

Arbitration:
- Only one source valid: it is granted.
- Both valid: the source not granted last is granted, and the pointer flips.
- The pointer updates only on a grant.

Write port:
- Latency is 1 cycle. The accepted request registers into o_rf_*, so o_rf_wen=1 appears the cycle after acceptance.
- No grant in a cycle: o_rf_wen=0 next cycle; addr and data hold their previous values.
- A request to x0 is accepted (ready=1) but produces o_rf_wen=0.

Scoreboard:
- Set rule: set busy[rd] when i_iss_valid & ~o_iss_stall & i_iss_rd_wen & rd!=0.
- Clear rule: clear busy[o_rf_addr] in a cycle where o_rf_wen=1.
- Same register set and cleared in one cycle: set wins.
- o_pend_cnt is the registered popcount of the next-state busy vector, so it matches o_busy every cycle.

Stall:
- o_iss_stall = i_iss_valid & (rs1 hazard | rs2 hazard | WAW).
- rsN hazard = cen & busy[rsN] & ~(o_rf_wen & o_rf_addr==rsN). A register being written this cycle does not stall, because the register file forwards write data on its write cycle.
- WAW = i_iss_rd_wen & busy[rd] & ~(o_rf_wen & o_rf_addr==rd).
- x0 never stalls.

Error case:
- A write-back to a register that is not busy is still written; its busy bit stays 0.

Decomposition:
Shared package:
- XLEN, AW, NREG constants
- source encoding: SRC_EXU=0, SRC_LSU=1

Sub-module: ysyx_210238_wb_rr_arb2, the 2-way round-robin arbiter (valid in, grant out, pointer register). The scoreboard and output stage stay in the top.

Test Plan:
- Reset: assert rst for 2 cycles mid-traffic with busy=0x0000_0006 -> next cycle o_busy=0, o_rf_wen=0, o_pend_cnt=0, o_iss_stall=1 during reset.
- RAW: issue rd=5 -> busy[5]=1.
  - Issue rs1=5 -> o_iss_stall=1.
  - EXU write-back to x5 with data 0xDEAD accepted -> next cycle o_rf_wen=1, o_rf_addr=5, o_rf_wdata=0xDEAD, o_iss_stall=0 in that same cycle.
  - The cycle after, busy[5]=0.
- Conflict: EXU(x3) and LSU(x4) both valid for 3 cycles -> grants EXU, LSU, EXU. o_rf_addr sequence 3, 4, 3 with 1-cycle lag.
- x0: LSU write-back to x0 -> o_lsu_ready=1, o_rf_wen stays 0. Issue with rd=0 -> busy unchanged. rs1=0 never stalls.
- Same-cycle set/clear: o_rf_wen to x7 while issuing a new rd=7 -> busy[7] remains 1. WAW issue with rd=7 one cycle later -> o_iss_stall=1.
- Count: issue rd=1..10 back-to-back -> o_pend_cnt=10. Retire all via LSU -> o_pend_cnt decrements to 0, o_busy=0.
